// File: rtl/spu_main_module_if.sv
// Issue/writeback bundle of the dual-pipe SPU core: pre-decoded even/odd
// instruction fields in, per-pipe register writeback out.
interface spu_main_module_if #(
  parameter int unsigned OPCODE_W  = 8,
  parameter int unsigned UNIT_ID_W = 3
);
  logic [UNIT_ID_W-1:0] unit_id;
  logic [OPCODE_W-1:0]  opcode_even;
  logic [OPCODE_W-1:0]  opcode_odd;
  logic [6:0]           addr_ra_rd_even;
  logic [6:0]           addr_rb_rd_even;
  logic [6:0]           addr_rc_rd_even;
  logic [6:0]           addr_rt_wt_even;
  logic [6:0]           addr_ra_rd_odd;
  logic [6:0]           addr_rb_rd_odd;
  logic [6:0]           addr_rc_rd_odd;
  logic [6:0]           addr_rt_wt_odd;
  logic [6:0]           imm7_even;
  logic [6:0]           imm7_odd;
  logic [9:0]           imm10_even;
  logic [9:0]           imm10_odd;
  logic [15:0]          imm16_odd;
  logic [17:0]          imm18_odd;
  logic                 init;
  logic                 init2;
  logic                 wb_en_even;
  logic                 wb_en_odd;
  logic [6:0]           wb_addr_even;
  logic [6:0]           wb_addr_odd;
  logic [127:0]         wb_data_even;
  logic [127:0]         wb_data_odd;

  modport master (
    output unit_id, opcode_even, opcode_odd,
    output addr_ra_rd_even, addr_rb_rd_even, addr_rc_rd_even, addr_rt_wt_even,
    output addr_ra_rd_odd, addr_rb_rd_odd, addr_rc_rd_odd, addr_rt_wt_odd,
    output imm7_even, imm7_odd, imm10_even, imm10_odd, imm16_odd, imm18_odd,
    output init, init2,
    input  wb_en_even, wb_en_odd, wb_addr_even, wb_addr_odd, wb_data_even, wb_data_odd
  );

  modport slave (
    input  unit_id, opcode_even, opcode_odd,
    input  addr_ra_rd_even, addr_rb_rd_even, addr_rc_rd_even, addr_rt_wt_even,
    input  addr_ra_rd_odd, addr_rb_rd_odd, addr_rc_rd_odd, addr_rt_wt_odd,
    input  imm7_even, imm7_odd, imm10_even, imm10_odd, imm16_odd, imm18_odd,
    input  init, init2,
    output wb_en_even, wb_en_odd, wb_addr_even, wb_addr_odd, wb_data_even, wb_data_odd
  );
endinterface

// File: rtl/spu_main_module.sv
// Dual-issue SPU execution core: even fixed-point pipe, odd permute/load-store
// pipe, 128x128 RF, local store. Optional RF/LS preload under SPU_INIT_PRELOAD_EN.
module spu_main_module #(
  parameter int unsigned LS_BYTES  = 2048,
  parameter int unsigned OPCODE_W  = 8,
  parameter int unsigned UNIT_ID_W = 3
) (
  input logic            clk,
  input logic            reset,
  spu_main_module_if.slave bus
);
  localparam int unsigned LS_QW   = LS_BYTES / 16;
  localparam int unsigned QA_W    = (LS_QW > 1) ? $clog2(LS_QW) : 1;
  localparam logic [31:0] EA_MASK = 32'(LS_BYTES - 1) & ~32'hF;

  localparam logic [OPCODE_W-1:0] OP_A       = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_AI      = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SHL     = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STQD    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STQX    = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_STQA    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LQD     = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ROTQBYI = OPCODE_W'(5);

`ifdef SPU_INIT_PRELOAD_EN
  localparam logic [127:0] PRELOAD_QW = 128'h00000005_00000007_0000000A_0000001F;
`endif

  typedef struct packed {
    logic         valid;
    logic [6:0]   rt;
    logic [127:0] data;
  } stage_t;

  stage_t               pe_q [3];
  stage_t               po_q [3];
  logic [UNIT_ID_W-1:0] uid_q [3];
  logic [127:0]         rf [128];
  logic [127:0]         ls [LS_QW];

  logic [127:0] ra_e, rb_e, ra_o, rb_o, rc_o;
  logic [127:0] res_e, res_o;
  logic         vld_e, vld_o, st_en;
  logic [5:0]   shamt;
  logic [31:0]  ea;
  logic [QA_W-1:0] ls_idx;
  logic [31:0]  imm10e_sx, imm10o_qw, imm16_wa;
  logic [6:0]   rot_bits;

  // Write-through read: same-cycle writes are visible, odd beats even, preload beats both.
  function automatic logic [127:0] rf_rd(input logic [6:0] a);
    logic [127:0] v;
    v = rf[a];
    if (pe_q[2].valid && pe_q[2].rt == a) v = pe_q[2].data;
    if (po_q[2].valid && po_q[2].rt == a) v = po_q[2].data;
`ifdef SPU_INIT_PRELOAD_EN
    if (bus.init && (a == 7'd0 || a == 7'd3)) v = PRELOAD_QW;
`endif
    return v;
  endfunction

  assign ra_e = rf_rd(bus.addr_ra_rd_even);
  assign rb_e = rf_rd(bus.addr_rb_rd_even);
  assign ra_o = rf_rd(bus.addr_ra_rd_odd);
  assign rb_o = rf_rd(bus.addr_rb_rd_odd);
  assign rc_o = rf_rd(bus.addr_rc_rd_odd);

  assign imm10e_sx = {{22{bus.imm10_even[9]}}, bus.imm10_even};
  assign imm10o_qw = {{18{bus.imm10_odd[9]}}, bus.imm10_odd, 4'b0000};
  assign imm16_wa  = {{14{bus.imm16_odd[15]}}, bus.imm16_odd, 2'b00};
  assign rot_bits  = {bus.imm7_odd[3:0], 3'b000};

  // Even pipe: word-wise ops are lane-symmetric, so lane order does not matter here.
  always_comb begin : even_exec
    res_e = '0;
    vld_e = 1'b0;
    shamt = '0;
    case (bus.opcode_even)
      OP_A: begin
        vld_e = 1'b1;
        for (int i = 0; i < 4; i++) res_e[32*i +: 32] = ra_e[32*i +: 32] + rb_e[32*i +: 32];
      end
      OP_AI: begin
        vld_e = 1'b1;
        for (int i = 0; i < 4; i++) res_e[32*i +: 32] = ra_e[32*i +: 32] + imm10e_sx;
      end
      OP_SHL: begin
        vld_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
          shamt = rb_e[32*i +: 6];
          res_e[32*i +: 32] = shamt[5] ? 32'd0 : (ra_e[32*i +: 32] << shamt[4:0]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin : odd_addr
    ea    = '0;
    st_en = 1'b0;
    case (bus.opcode_odd)
      OP_STQD: begin st_en = 1'b1; ea = ra_o[127:96] + imm10o_qw; end
      OP_STQX: begin st_en = 1'b1; ea = ra_o[127:96] + rb_o[127:96]; end
      OP_STQA: begin st_en = 1'b1; ea = imm16_wa; end
      OP_LQD:  ea = ra_o[127:96] + imm10o_qw;
      default: ;
    endcase
  end

  assign ls_idx = QA_W'((ea & EA_MASK) >> 4);

  always_comb begin : odd_exec
    res_o = '0;
    vld_o = 1'b0;
    case (bus.opcode_odd)
      OP_LQD: begin
        vld_o = 1'b1;
        res_o = ls[ls_idx];
      end
      OP_ROTQBYI: begin
        vld_o = 1'b1;
        res_o = (ra_o << rot_bits) | (ra_o >> (8'd128 - {1'b0, rot_bits}));
      end
      default: ;
    endcase
  end

  // Three stage registers per pipe; stage 2 drives writeback in cycle N+3.
  always_ff @(posedge clk or posedge reset) begin : pipes
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        pe_q[k]  <= '0;
        po_q[k]  <= '0;
        uid_q[k] <= '0;
      end
    end else begin
      pe_q[0]  <= '{vld_e, bus.addr_rt_wt_even, res_e};
      po_q[0]  <= '{vld_o, bus.addr_rt_wt_odd, res_o};
      uid_q[0] <= bus.unit_id;
      for (int k = 1; k < 3; k++) begin
        pe_q[k]  <= pe_q[k-1];
        po_q[k]  <= po_q[k-1];
        uid_q[k] <= uid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : rf_write
    if (reset) begin
      for (int k = 0; k < 128; k++) rf[k] <= '0;
    end else begin
      if (pe_q[2].valid) rf[pe_q[2].rt] <= pe_q[2].data;
      if (po_q[2].valid) rf[po_q[2].rt] <= po_q[2].data;
`ifdef SPU_INIT_PRELOAD_EN
      if (bus.init) begin
        rf[0] <= PRELOAD_QW;
        rf[3] <= PRELOAD_QW;
      end
`endif
    end
  end

  // Local store keeps its contents across reset.
  always_ff @(posedge clk) begin : ls_write
`ifdef SPU_INIT_PRELOAD_EN
    if (bus.init2) begin
      for (int k = 0; k < LS_QW; k++) ls[k] <= '0;
    end else if (st_en) begin
      ls[ls_idx] <= rc_o;
    end
`else
    if (st_en) ls[ls_idx] <= rc_o;
`endif
  end

  assign bus.wb_en_even   = pe_q[2].valid;
  assign bus.wb_addr_even = pe_q[2].rt;
  assign bus.wb_data_even = pe_q[2].data;
  assign bus.wb_en_odd    = po_q[2].valid;
  assign bus.wb_addr_odd  = po_q[2].rt;
  assign bus.wb_data_odd  = po_q[2].data;

  // Fields that are carried or reserved but never steer execution.
  logic unused_ok;
`ifdef SPU_INIT_PRELOAD_EN
  assign unused_ok = ^{bus.imm18_odd, bus.imm7_even, bus.imm7_odd[6:4],
                       bus.addr_rc_rd_even, rb_o[95:0], uid_q[2]};
`else
  assign unused_ok = ^{bus.imm18_odd, bus.imm7_even, bus.imm7_odd[6:4],
                       bus.addr_rc_rd_even, rb_o[95:0], uid_q[2], bus.init, bus.init2};
`endif
endmodule

// File: tb/tb_spu_main_module.sv
// Scoreboard bench for spu_main_module: byte/word-level reference model predicts
// every writeback; a negedge monitor pops and compares both pipes.
module tb_spu_main_module;
  localparam int unsigned LS_BYTES  = 2048;
  localparam int unsigned OPCODE_W  = 8;
  localparam int unsigned UNIT_ID_W = 3;
`ifdef SPU_INIT_PRELOAD_EN
  localparam logic [127:0] PRE = 128'h00000005_00000007_0000000A_0000001F;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spu_main_module_if #(.OPCODE_W(OPCODE_W), .UNIT_ID_W(UNIT_ID_W)) bus ();

  spu_main_module #(.LS_BYTES(LS_BYTES), .OPCODE_W(OPCODE_W), .UNIT_ID_W(UNIT_ID_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int op_e, ra_e, rb_e, rt_e, imm10_e;
    int op_o, ra_o, rb_o, rc_o, rt_o, imm7_o, imm10_o, imm16_o;
    bit init, init2;
  } ins_t;

  typedef struct {
    int           due;
    logic [6:0]   rt;
    logic [127:0] data;
  } wb_t;

  wb_t          exp_e[$], exp_o[$], pend[$];
  logic [127:0] rf_m [128];
  logic [7:0]   ls_m [LS_BYTES];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  function automatic logic [7:0] byt(input logic [127:0] v, input int j);
    return v[127-8*j -: 8];
  endfunction

  function automatic int sx10(input logic [9:0] v);
    return v[9] ? int'(v) - 1024 : int'(v);
  endfunction

  function automatic int sx16(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic ins_t nop_i();
    ins_t r;
    r = '{default: 0};
    return r;
  endfunction

  function automatic ins_t e_i(input int op, input int ra, input int rb, input int rt, input int imm10);
    ins_t r;
    r = nop_i();
    r.op_e = op; r.ra_e = ra; r.rb_e = rb; r.rt_e = rt; r.imm10_e = imm10;
    return r;
  endfunction

  function automatic ins_t o_i(input int op, input int ra, input int rb, input int rc, input int rt,
                               input int imm7, input int imm10, input int imm16);
    ins_t r;
    r = nop_i();
    r.op_o = op; r.ra_o = ra; r.rb_o = rb; r.rc_o = rc; r.rt_o = rt;
    r.imm7_o = imm7; r.imm10_o = imm10; r.imm16_o = imm16;
    return r;
  endfunction

  task automatic drive(input ins_t x);
    bus.opcode_even     = OPCODE_W'(x.op_e);
    bus.addr_ra_rd_even = 7'(x.ra_e);
    bus.addr_rb_rd_even = 7'(x.rb_e);
    bus.addr_rt_wt_even = 7'(x.rt_e);
    bus.imm10_even      = 10'(x.imm10_e);
    bus.opcode_odd      = OPCODE_W'(x.op_o);
    bus.addr_ra_rd_odd  = 7'(x.ra_o);
    bus.addr_rb_rd_odd  = 7'(x.rb_o);
    bus.addr_rc_rd_odd  = 7'(x.rc_o);
    bus.addr_rt_wt_odd  = 7'(x.rt_o);
    bus.imm7_odd        = 7'(x.imm7_o);
    bus.imm10_odd       = 10'(x.imm10_o);
    bus.imm16_odd       = 16'(x.imm16_o);
    bus.init            = x.init;
    bus.init2           = x.init2;
    bus.unit_id         = UNIT_ID_W'($urandom);
    bus.imm18_odd       = 18'($urandom);
    bus.imm7_even       = 7'($urandom);
    bus.addr_rc_rd_even = 7'($urandom);
  endtask

  // Register writes land at the end of their due cycle; a read in that cycle already sees them.
  task automatic commit(input int n);
    while (pend.size() > 0 && pend[0].due <= n) begin
      rf_m[pend[0].rt] = pend[0].data;
      void'(pend.pop_front());
    end
  endtask

  task automatic step(input ins_t x);
    logic [127:0] ra_e, rb_e, ra_o, rb_o, rc_o, re, ro;
    logic [31:0]  w, s, ea;
    int n, base, rot;
    bit ve, vo;
    @(posedge clk);
    #1;
    drive(x);
    n = cyc;
    commit(n);
    ra_e = rf_m[x.ra_e]; rb_e = rf_m[x.rb_e];
    ra_o = rf_m[x.ra_o]; rb_o = rf_m[x.rb_o]; rc_o = rf_m[x.rc_o];
    re = '0;
    ve = (x.op_e >= 1 && x.op_e <= 3);
    for (int i = 0; i < 4; i++) begin
      w = word(ra_e, i);
      if (x.op_e == 1) w = w + word(rb_e, i);
      if (x.op_e == 2) w = w + 32'(sx10(10'(x.imm10_e)));
      if (x.op_e == 3) begin
        s = word(rb_e, i) % 64;
        w = (s > 31) ? 32'd0 : (w << s);
      end
      re[127-32*i -: 32] = w;
    end
    ro = '0;
    vo = (x.op_o == 4 || x.op_o == 5);
    case (x.op_o)
      1, 4:    ea = word(ra_o, 0) + 32'(sx10(10'(x.imm10_o)) * 16);
      2:       ea = word(ra_o, 0) + word(rb_o, 0);
      3:       ea = 32'(sx16(16'(x.imm16_o)) * 4);
      default: ea = 32'd0;
    endcase
    base = int'(ea % LS_BYTES) / 16 * 16;
    if (x.op_o >= 1 && x.op_o <= 3)
      for (int j = 0; j < 16; j++) ls_m[base+j] = byt(rc_o, j);
    if (x.op_o == 4)
      for (int j = 0; j < 16; j++) ro[127-8*j -: 8] = ls_m[base+j];
    if (x.op_o == 5) begin
      rot = x.imm7_o % 16;
      for (int j = 0; j < 16; j++) ro[127-8*j -: 8] = byt(ra_o, (j + rot) % 16);
    end
`ifdef SPU_INIT_PRELOAD_EN
    if (x.init) begin
      rf_m[0] = PRE;
      rf_m[3] = PRE;
    end
    if (x.init2) for (int j = 0; j < LS_BYTES; j++) ls_m[j] = 8'h00;
`endif
    if (ve) begin
      exp_e.push_back('{due: n + 3, rt: 7'(x.rt_e), data: re});
      pend.push_back('{due: n + 3, rt: 7'(x.rt_e), data: re});
    end
    if (vo) begin
      exp_o.push_back('{due: n + 3, rt: 7'(x.rt_o), data: ro});
      pend.push_back('{due: n + 3, rt: 7'(x.rt_o), data: ro});
    end
  endtask

  task automatic nops(input int k);
    for (int i = 0; i < k; i++) step(nop_i());
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    drive(nop_i());
    reset = 1'b1;
    exp_e.delete(); exp_o.delete(); pend.delete();
    for (int k = 0; k < 128; k++) rf_m[k] = '0;
    repeat (ncyc) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      ins_t x;
      x = nop_i();
      x.op_e = $urandom_range(0, 5);
      x.ra_e = $urandom_range(0, 31); x.rb_e = $urandom_range(0, 31); x.rt_e = $urandom_range(0, 31);
      x.imm10_e = $urandom_range(0, 1023);
      x.op_o = $urandom_range(0, 7);
      x.ra_o = $urandom_range(0, 31); x.rb_o = $urandom_range(0, 31);
      x.rc_o = $urandom_range(0, 31); x.rt_o = $urandom_range(0, 31);
      x.imm7_o = $urandom_range(0, 127); x.imm10_o = $urandom_range(0, 1023);
      x.imm16_o = $urandom_range(0, 65535);
      step(x);
    end
  endtask

  task automatic mon_pipe(input string nm, input logic en, input logic [6:0] a, input logic [127:0] d,
                          input bit has, input wb_t h, output bit pop);
    pop = 1'b0;
    if (has && h.due == cyc) begin
      check({nm, "_en"}, 128'(en), 128'(1'b1));
      check({nm, "_addr"}, 128'(a), 128'(h.rt));
      check({nm, "_data"}, d, h.data);
      pop = 1'b1;
    end else if (has && h.due < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_missed: writeback due cyc %0d never seen", nm, h.due);
      pop = 1'b1;
    end else begin
      check({nm, "_idle"}, {bus.wb_en_even & 1'b0, 127'(en)}, 128'(0));
    end
  endtask

  always @(negedge clk) begin : monitor
    wb_t h;
    bit  has, p;
    has = exp_e.size() > 0;
    h = has ? exp_e[0] : '{due: 0, rt: 7'd0, data: 128'd0};
    mon_pipe("even", bus.wb_en_even, bus.wb_addr_even, bus.wb_data_even, has, h, p);
    if (p) void'(exp_e.pop_front());
    has = exp_o.size() > 0;
    h = has ? exp_o[0] : '{due: 0, rt: 7'd0, data: 128'd0};
    mon_pipe("odd", bus.wb_en_odd, bus.wb_addr_odd, bus.wb_data_odd, has, h, p);
    if (p) void'(exp_o.pop_front());
  end

  initial begin : stim
    ins_t x, y;
    for (int k = 0; k < 128; k++) rf_m[k] = '0;
    for (int j = 0; j < LS_BYTES; j++) ls_m[j] = 8'h00;
    reset = 1'b1;
    drive(nop_i());
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_wb_data_even", bus.wb_data_even, 128'd0);
    check("rst_wb_addr_odd", 128'(bus.wb_addr_odd), 128'd0);

    // Give every local-store quadword a known value (zeros from the cleared RF).
    for (int q = 0; q < int'(LS_BYTES / 16); q++) step(o_i(3, 0, 0, 0, 0, 0, 0, q * 4));

    step(e_i(2, 0, 0, 1, 5));              nops(3);
    step(e_i(2, 1, 0, 2, 4));              nops(3);
    step(e_i(1, 2, 1, 3, 0));              nops(3);

    step(o_i(1, 2, 0, 3, 0, 0, 10, 0));
    step(o_i(2, 2, 3, 1, 0, 0, 0, 0));
    step(o_i(3, 0, 0, 2, 0, 0, 0, 10));
    step(o_i(4, 2, 0, 0, 5, 0, 10, 0));    nops(3);

    step(o_i(5, 2, 0, 0, 12, 2, 0, 0));    nops(3);
    step(e_i(3, 12, 1, 10, 0));
    step(e_i(2, 0, 0, 20, 32));            nops(3);
    step(e_i(3, 3, 20, 21, 0));            nops(3);
    step(o_i(4, 2, 0, 0, 22, 0, 1023, 0)); nops(3);

    // Both pipes target r7 together; three cycles later read r7 in its write cycle.
    x = e_i(2, 0, 0, 7, 1);
    y = o_i(5, 3, 0, 0, 7, 0, 0, 0);
    x.op_o = y.op_o; x.ra_o = y.ra_o; x.rt_o = y.rt_o;
    step(x);
    nops(2);
    x = e_i(1, 7, 0, 8, 0);
    y = o_i(5, 7, 0, 0, 9, 3, 0, 0);
    x.op_o = y.op_o; x.ra_o = y.ra_o; x.rt_o = y.rt_o; x.imm7_o = y.imm7_o;
    step(x);
    nops(3);

    rand_phase(300);

    step(e_i(2, 1, 0, 1, 3));
    step(o_i(5, 2, 0, 0, 2, 1, 0, 0));
    step(e_i(2, 3, 0, 3, 7));
    do_reset(2);
    for (int k = 0; k < 128; k++) step(o_i(5, k, 0, 0, k, 0, 0, 0));
    nops(3);

    x = nop_i();
    x.init = 1'b1;
    step(x);
    step(o_i(5, 0, 0, 0, 40, 0, 0, 0));
    step(o_i(5, 3, 0, 0, 41, 4, 0, 0));
    x = nop_i();
    x.init2 = 1'b1;
    step(x);
    step(o_i(4, 0, 0, 0, 42, 0, 0, 0));
    nops(3);

    rand_phase(300);
    nops(6);
    check("drain_even", 128'(exp_e.size()), 128'd0);
    check("drain_odd", 128'(exp_o.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
